phys_ram_arbiter: RTL

PHYS_RAM_ARBITER -- requirements
Module: phys_ram_arbiter

---
 rtl/phys_ram_pkg.sv | 18 +
 rtl/phys_ram_arbiter_if.sv | 24 ++
 rtl/phys_ram_arbiter_rr.sv | 28 ++
 rtl/phys_ram_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/phys_ram_pkg.sv
// Shared types and constants for the PhysicalRAM arbiter.
// Holds the FSM state enum and read-latency counter width.
package phys_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arbState_e;

  localparam int LAT_CNT_W = 2;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phys_ram_arbiter_if.sv
// Requester-side bus of the PhysicalRAM arbiter.
// Channel fields are packed, channel i at slice i.
interface phys_ram_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        chReq;
  logic [NUM_CH-1:0]        chWe;
  logic [NUM_CH*ADDR_W-1:0] chAddr;
  logic [NUM_CH*DATA_W-1:0] chWData;
  logic [NUM_CH-1:0]        chAck;
  logic [DATA_W-1:0]        chRData;

  modport master (
    output chReq, chWe, chAddr, chWData,
    input  chAck, chRData
  );

  modport slave (
    input  chReq, chWe, chAddr, chWData,
    output chAck, chRData
  );
endinterface

// File: rtl/phys_ram_arbiter_rr.sv
// Combinational round-robin picker.
// Search starts one past the last granted channel.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  lastGrant,
  output logic [NUM_CH-1:0] grant
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = IDX_W'((int'(lastGrant) + k) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phys_ram_arbiter.sv
// Multi-channel arbiter in front of a single-port PhysicalRAM.
// One transaction in flight; round-robin between channels.
module phys_ram_arbiter
  import phys_ram_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  phys_ram_arbiter_if.slave chBus,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramWriteEnable,
  output logic [DATA_W-1:0] ramWrite,
  input  logic [DATA_W-1:0] ramRead
);

  localparam int IDX_W = idxW(NUM_CH);

  arbState_e state, nextState;

  logic [NUM_CH-1:0]    rrGrant;
  logic [IDX_W-1:0]     rrIdx;
  logic [IDX_W-1:0]     lastGrant;
  logic [IDX_W-1:0]     grantIdx;
  logic [ADDR_W-1:0]    addrQ;
  logic [DATA_W-1:0]    dataQ;
  logic                 weQ;
  logic [LAT_CNT_W-1:0] latCnt;
  logic                 latDone;
  logic [DATA_W-1:0]    rdataQ;
  logic [NUM_CH-1:0]    ackVec;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) uRr (
    .req       (chBus.chReq),
    .lastGrant (lastGrant),
    .grant     (rrGrant)
  );

  always_comb begin
    rrIdx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rrGrant[i]) rrIdx = IDX_W'(i);
    end
  end

  assign latDone = (latCnt == LAT_CNT_W'(READ_LAT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= IDX_W'(NUM_CH - 1);
      grantIdx  <= '0;
      addrQ     <= '0;
      dataQ     <= '0;
      weQ       <= 1'b0;
      latCnt    <= '0;
      rdataQ    <= '0;
    end else begin
      state <= nextState;
      // Snapshot the request so later requester edits are ignored.
      if (state == IDLE && |chBus.chReq) begin
        grantIdx <= rrIdx;
        addrQ    <= chBus.chAddr[int'(rrIdx)*ADDR_W +: ADDR_W];
        dataQ    <= chBus.chWData[int'(rrIdx)*DATA_W +: DATA_W];
        weQ      <= chBus.chWe[rrIdx];
      end
      if (state == ISSUE) begin
        latCnt <= '0;
      end else if (state == WAIT) begin
        latCnt <= latCnt + 1'b1;
      end
      if (state == WAIT && latDone) rdataQ <= ramRead;
      if (state == ACK) lastGrant <= grantIdx;
    end
  end

  always_comb begin
    nextState      = state;
    ramWriteEnable = 1'b0;
    ackVec         = '0;
    unique case (state)
      IDLE: begin
        if (|chBus.chReq) nextState = ISSUE;
      end
      ISSUE: begin
        ramWriteEnable = weQ;
        nextState      = weQ ? ACK : WAIT;
      end
      WAIT: begin
        if (latDone) nextState = ACK;
      end
      ACK: begin
        ackVec    = NUM_CH'(1) << grantIdx;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign ramAddress    = addrQ;
  assign ramWrite      = dataQ;
  assign chBus.chAck   = ackVec;
  assign chBus.chRData = rdataQ;

endmodule
